seq_wide_adder_ctrl: RTL and testbench

- Multi-cycle sequencer that performs one W = N*WORDS bit addition using a single N-bit ripple-carry adder slice.
- The slice is reused once per cycle, least-significant slice first, and the carry is registered between slices.
- Sits between a requester (start/done handshake) and the shared N-bit adder datapath.
- Trades latency for area in wide-operand arithmetic.

---
 rtl/seq_wide_adder_ctrl.sv | 155 +++++++++++++++
 tb/tb_seq_wide_adder_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_wide_adder_ctrl.sv
// ---------------------------------------------------------------------------
// seq_wide_adder_ctrl
//
// Performs one W = N*WORDS bit addition by reusing a single N-bit ripple
// adder slice once per cycle, least-significant slice first. The carry
// between slices is held in a register, so an operation takes WORDS RUN
// cycles followed by a one-cycle DONE state.
//
// Optional build macro: SEQ_WIDE_ADDER_SUB_EN
//   When defined, adds input 'sub'. With sub=1 the block computes a - b as
//   a + ~b + 1 (b inverted at capture, carry seeded with 1, cin ignored);
//   cout=1 then means no borrow. When undefined the block only adds.
//
// Ports:
//   clk    in   1  rising-edge clock
//   rst    in   1  asynchronous active-high reset
//   start  in   1  request, sampled only in IDLE or DONE
//   a      in   W  operand A, captured on an accepted start
//   b      in   W  operand B, captured on an accepted start
//   cin    in   1  carry into slice 0, captured on an accepted start
//   sub    in   1  subtract select (only with SEQ_WIDE_ADDER_SUB_EN)
//   busy   out  1  high while the slices are being processed
//   done   out  1  one-cycle pulse, sum/cout valid in this cycle
//   sum    out  W  result register
//   cout   out  1  carry out of the top slice
// ---------------------------------------------------------------------------
module seq_wide_adder_ctrl #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N*WORDS-1:0]   a,
  input  logic [N*WORDS-1:0]   b,
  input  logic                 cin,
`ifdef SEQ_WIDE_ADDER_SUB_EN
  input  logic                 sub,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [N*WORDS-1:0]   sum,
  output logic                 cout
);

  localparam int W  = N * WORDS;
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [KW-1:0] K_LAST     = KW'(WORDS - 1);
  localparam logic [W-1:0]  SLICE_MASK = W'({N{1'b1}});

  logic [1:0]    state_r;
  logic [KW-1:0] k_r;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic          carry_r;
  logic [W-1:0]  sum_r;
  logic          cout_r;
  logic          busy_r;
  logic          done_r;

  logic [W-1:0]  b_cap_s;
  logic          carry_cap_s;
  logic [31:0]   sh_s;
  logic [N-1:0]  slice_a_s;
  logic [N-1:0]  slice_b_s;
  logic [N:0]    slice_res_s;
  logic [W-1:0]  sum_next_s;

  // Operand conditioning applied at capture time (subtract folds into b and the carry seed).
  always_comb begin
`ifdef SEQ_WIDE_ADDER_SUB_EN
    if (sub) begin
      b_cap_s     = ~b;
      carry_cap_s = 1'b1;
    end else begin
      b_cap_s     = b;
      carry_cap_s = cin;
    end
`else
    b_cap_s     = b;
    carry_cap_s = cin;
`endif
  end

  // The single shared N-bit slice adder and the merge of its result into the sum register.
  always_comb begin
    sh_s        = 32'(k_r) * 32'(N);
    slice_a_s   = N'(a_r >> sh_s);
    slice_b_s   = N'(b_r >> sh_s);
    slice_res_s = {1'b0, slice_a_s} + {1'b0, slice_b_s} + {{N{1'b0}}, carry_r};
    // Replace only the active slice position; other slices keep their value.
    sum_next_s  = (sum_r & ~(SLICE_MASK << sh_s)) | (W'(slice_res_s[N-1:0]) << sh_s);
  end

  // Sequencer state, operand capture, slice stepping and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      k_r     <= {KW{1'b0}};
      a_r     <= {W{1'b0}};
      b_r     <= {W{1'b0}};
      carry_r <= 1'b0;
      sum_r   <= {W{1'b0}};
      cout_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (start) begin
            a_r     <= a;
            b_r     <= b_cap_s;
            carry_r <= carry_cap_s;
            k_r     <= {KW{1'b0}};
            sum_r   <= {W{1'b0}};
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          sum_r   <= sum_next_s;
          carry_r <= slice_res_s[N];
          if (k_r == K_LAST) begin
            cout_r  <= slice_res_s[N];
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            k_r     <= k_r + KW'(1);
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_seq_wide_adder_ctrl.sv
// ---------------------------------------------------------------------------
// Self-checking bench for seq_wide_adder_ctrl (N=4, WORDS=4).
// Expected results come from plain W-bit arithmetic on the applied operands.
// Build with +define+SEQ_WIDE_ADDER_SUB_EN to exercise the subtract mode.
// ---------------------------------------------------------------------------
module tb_seq_wide_adder_ctrl;

  localparam int N     = 4;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int total;
  int bad;
  logic last_cout;

  seq_wide_adder_ctrl #(.N(N), .WORDS(WORDS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SEQ_WIDE_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {cout, sum} of the full-width operation.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c, input logic s);
    logic [W:0] r;
`ifdef SEQ_WIDE_ADDER_SUB_EN
    if (s) begin
      r = {(x >= y) ? 1'b1 : 1'b0, W'(x - y)};
    end else begin
      r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    end
`else
    r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    if (s) r = {W+1{1'bx}};
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation from IDLE; operands are scrambled right after acceptance.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tcin, input logic tsub);
    logic [W:0] exp;
    int n;
    int bc;
    exp   = model(ta, tb_v, tcin, tsub);
    a     = ta;
    b     = tb_v;
    cin   = tcin;
    sub   = tsub;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
    sub   = 1'($urandom);
    check({tag, "_sum_cleared"}, 64'(sum), 64'(0));
    check({tag, "_cout_held"}, 64'(cout), 64'(last_cout));
    n  = 1;
    bc = 0;
    while (done !== 1'b1 && n < 20) begin
      if (busy === 1'b1) bc++;
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(WORDS + 1));
    check({tag, "_busy_cycles"}, 64'(bc), 64'(WORDS));
    check({tag, "_sum"}, 64'(sum), 64'(exp[W-1:0]));
    check({tag, "_cout"}, 64'(cout), 64'(exp[W]));
    check({tag, "_busy_in_done"}, 64'(busy), 64'(0));
    last_cout = exp[W];
    tick();
    check({tag, "_done_pulse"}, 64'(done), 64'(0));
    check({tag, "_sum_hold"}, 64'(sum), 64'(exp[W-1:0]));
  endtask

  initial begin
    logic [W:0]   exp1;
    logic [W:0]   exp2;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    int n;
    int dcount;

    total     = 0;
    bad       = 0;
    last_cout = 1'b0;
    rst       = 1'b1;
    start     = 1'b0;
    a         = {W{1'b0}};
    b         = {W{1'b0}};
    cin       = 1'b0;
    sub       = 1'b0;
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_sum",  64'(sum),  64'(0));
    check("rst_cout", 64'(cout), 64'(0));
    rst = 1'b0;
    tick();

    // Directed cases.
    run_op("basic",  16'h1234, 16'h4321, 1'b0, 1'b0);
    run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_op("cin_a",  16'h0000, 16'hFFFF, 1'b1, 1'b0);
    run_op("cin_b",  16'h00FF, 16'h0000, 1'b1, 1'b0);

    // Back-to-back with start held high; RUN-cycle operands become the second op.
    exp1  = model(16'hA5C3, 16'h5A3D, 1'b1, 1'b0);
    a     = 16'hA5C3;
    b     = 16'h5A3D;
    cin   = 1'b1;
    sub   = 1'b0;
    start = 1'b1;
    tick();
    ra    = W'($urandom);
    rb    = W'($urandom);
    rc    = 1'($urandom);
    a     = ra;
    b     = rb;
    cin   = rc;
    exp2  = model(ra, rb, rc, 1'b0);
    n = 1;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("b2b_lat1", 64'(n), 64'(WORDS + 1));
    check("b2b_sum1", 64'(sum), 64'(exp1[W-1:0]));
    check("b2b_cout1", 64'(cout), 64'(exp1[W]));
    tick();
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    check("b2b_accepted", 64'(busy), 64'(1));
    n = 1;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("b2b_spacing", 64'(n), 64'(WORDS + 1));
    check("b2b_sum2", 64'(sum), 64'(exp2[W-1:0]));
    check("b2b_cout2", 64'(cout), 64'(exp2[W]));
    last_cout = exp2[W];
    tick();

    // Reset during the second RUN cycle.
    run_op("pre_rst", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    a     = 16'h1111;
    b     = 16'h1111;
    cin   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_done", 64'(done), 64'(0));
    check("mid_rst_sum",  64'(sum),  64'(0));
    check("mid_rst_cout", 64'(cout), 64'(0));
    tick();
    rst = 1'b0;
    last_cout = 1'b0;
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) dcount++;
      tick();
    end
    check("mid_rst_no_done", 64'(dcount), 64'(0));
    run_op("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0);

`ifdef SEQ_WIDE_ADDER_SUB_EN
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1);
    run_op("sub_ok",     16'h0007, 16'h0005, 1'b1, 1'b1);
    run_op("sub0_add",   16'h1234, 16'h4321, 1'b0, 1'b0);
`endif

    // Random operations.
    for (int i = 0; i < 10; i++) begin
`ifdef SEQ_WIDE_ADDER_SUB_EN
      run_op("rand", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
`else
      run_op("rand", W'($urandom), W'($urandom), 1'($urandom), 1'b0);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
